bytewise_logic_seq: RTL and testbench
=====================================

Name: bytewise_logic_seq

Overview:
- Multi-cycle controller that computes a 32-bit bitwise logic operation (AND/OR/XOR/NOR) by time-sharing a single internal 8-bit logic slice over four cycles, least-significant byte first.
- Sits beside the ALU in the MIPS32 datapath as a low-area alternative to the full-width logic unit.
- Sequences operand byte selection, result assembly, start/done handshake and abort.

Parameters:
- none (width fixed at 32 bits, 4 bytes).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only in IDLE or DONE state.
- flush  in  1  synchronous abort; highest priority after reset.
- op  in  2  00 AND, 01 OR, 10 XOR, 11 NOR; sampled on accept.
- a  in  32  operand A; sampled on accept.
- b  in  32  operand B; sampled on accept.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- result  out  32  assembled result.
- zero  out  1  result == 0, valid with done.
- byte_idx  out  2  byte currently processed (observability).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, result=0, zero=0, byte_idx=0.
  - Latched operands and op cleared.
- States: IDLE, RUN, DONE.
- Accept: start=1 in IDLE or DONE at edge T.
  - a, b and op are latched.
  - result cleared to 0, byte_idx=0.
  - State becomes RUN, so busy=1 from cycle T+1.
- RUN: each rising edge writes result[8k+7:8k] = slice(op, a_lat[8k+7:8k], b_lat[8k+7:8k]) with k=byte_idx, then increments byte_idx.
  - The edge that writes byte 3 moves to DONE; byte_idx wraps to 0.
- DONE: lasts exactly one cycle.
  - done=1, busy=0.
  - zero = (result==0), registered on the same edge that enters DONE.
  - Next state is IDLE, or RUN if start=1 (back-to-back, no bubble).
- Latency: start accepted at edge T → done high in cycle T+5.
  - Four RUN cycles; throughput one op per 5 cycles.
- start during RUN is ignored; no queueing.
- a, b and op changing during RUN have no effect.
- result and zero hold after DONE until the next accept.
- flush=1 at any edge in RUN or DONE:
  - state goes to IDLE, busy=0, done=0, byte_idx=0.
  - result keeps its partial value, zero unchanged.
  - flush and start together: flush wins, start is dropped.
- Slice function is combinational: AND a&b, OR a|b, XOR a^b, NOR ~(a|b), all 8-bit.
- Mid-operation rst_n assertion aborts immediately to the reset values; no done pulse is produced.

Test Plan:
- Reset then OR: a=0x12345678, b=0x0F0F0000, op=01 → busy high 4 cycles; byte_idx 0,1,2,3; done in cycle T+5; result=0x1F3F5678, zero=0.
- AND/NOR: AND a=0xFFFF0000, b=0x0F0F0F0F → 0x0F0F0000. NOR a=0, b=0 → 0xFFFFFFFF, zero=0.
- XOR with a=b=0xDEADBEEF → result=0x00000000, zero=1 in the done cycle.
- Back-to-back: start held high through DONE with a new operand set → second op enters RUN with no idle cycle; second done exactly 5 cycles after the first; start pulses during RUN are ignored.
- flush in the 2nd RUN cycle → busy=0 next cycle, no done; result=0x00000078 (byte 0 only, OR example); a new start completes normally.
- rst_n asserted asynchronously mid-RUN → all outputs 0 immediately, without waiting for a clock edge; after release the block is IDLE and accepts start.

Source files
------------

// File: rtl/bytewise_logic_seq.sv
// 32-bit AND/OR/XOR/NOR computed over four cycles through one shared 8-bit slice.
// Bytes are processed LSB first; start/done handshake with synchronous flush.
module bytewise_logic_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        zero,
    output logic [1:0]  byte_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] a_lat;
    logic [31:0] b_lat;
    logic [1:0]  op_lat;
    logic        accept;
    logic        step;
    logic        last;
    logic [4:0]  bit_base;
    logic [7:0]  a_byte;
    logic [7:0]  b_byte;
    logic [7:0]  slice;
    logic [31:0] result_nxt;

    assign bit_base = {byte_idx, 3'b000};
    assign a_byte   = a_lat[bit_base +: 8];
    assign b_byte   = b_lat[bit_base +: 8];
    assign last     = (byte_idx == 2'd3);

    always_comb begin
        slice = '0;
        case (op_lat)
            OP_AND:  slice = a_byte & b_byte;
            OP_OR:   slice = a_byte | b_byte;
            OP_XOR:  slice = a_byte ^ b_byte;
            OP_NOR:  slice = ~(a_byte | b_byte);
            default: slice = '0;
        endcase
    end

    always_comb begin
        result_nxt = result;
        result_nxt[bit_base +: 8] = slice;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush overrides everything, including a coincident start.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    step = 1'b1;
                    if (last) begin
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (start) begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lat    <= '0;
            b_lat    <= '0;
            op_lat   <= '0;
            result   <= '0;
            zero     <= 1'b0;
            byte_idx <= '0;
        end else if (flush) begin
            byte_idx <= '0;
        end else if (accept) begin
            a_lat    <= a;
            b_lat    <= b;
            op_lat   <= op;
            result   <= '0;
            byte_idx <= '0;
        end else if (step) begin
            result   <= result_nxt;
            byte_idx <= byte_idx + 2'd1;
            if (last) begin
                zero <= (result_nxt == 32'd0);
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bytewise_logic_seq.sv
// Directed bench for bytewise_logic_seq: ops, back-to-back, flush, async reset.
// Outputs are sampled on the falling clock edge.
module tb_bytewise_logic_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic [1:0]  byte_idx;

    int n_tests;
    int n_fail;

    bytewise_logic_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .flush    (flush),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .byte_idx (byte_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] r,
                          input logic z, input string tag);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = 32'h5A5A_A5A5;
        b     = 32'hC3C3_3C3C;
        op    = ~o;
        for (int k = 0; k < 4; k++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_idx"}, 32'(byte_idx), 32'(k));
            check({tag, "_nodone"}, 32'(done), 32'd0);
            @(negedge clk);
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_dbusy"}, 32'(busy), 32'd0);
        check({tag, "_res"}, result, r);
        check({tag, "_zero"}, 32'(zero), 32'(z));
        @(negedge clk);
        check({tag, "_done_off"}, 32'(done), 32'd0);
        check({tag, "_hold"}, result, r);
        check({tag, "_zhold"}, 32'(zero), 32'(z));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        op      = 2'b00;
        a       = '0;
        b       = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_idx", 32'(byte_idx), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        run_op(2'b01, 32'h1234_5678, 32'h0F0F_0000, 32'h1F3F_5678, 1'b0, "or");
        run_op(2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 1'b0, "and");
        run_op(2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, "xor");
        run_op(2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "nor");

        // back-to-back: start held high, second op enters RUN from DONE
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'h1234_5678;
        b     = 32'h0F0F_0000;
        @(negedge clk);
        op    = 2'b11;
        a     = 32'hAAAA_AAAA;
        b     = 32'h5555_5555;
        check("b2b_run0", 32'(byte_idx), 32'd0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("b2b_idx", 32'(byte_idx), 32'(k));
        end
        @(negedge clk);
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_res1", result, 32'h1F3F_5678);
        op = 2'b00;
        a  = 32'hFFFF_0000;
        b  = 32'h0F0F_0F0F;
        @(negedge clk);
        start = 1'b0;
        check("b2b_nobubble", 32'(busy), 32'd1);
        check("b2b_idx0", 32'(byte_idx), 32'd0);
        check("b2b_cleared", result, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("b2b_nodone", 32'(done), 32'd0);
        end
        @(negedge clk);
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_res2", result, 32'h0F0F_0000);
        @(negedge clk);

        // flush during the second RUN cycle, with a coincident start
        start = 1'b1;
        op    = 2'b01;
        a     = 32'h1234_5678;
        b     = 32'h0F0F_0000;
        @(negedge clk);
        start = 1'b0;
        check("fl_run1", 32'(busy), 32'd1);
        @(negedge clk);
        check("fl_run2_idx", 32'(byte_idx), 32'd1);
        flush = 1'b1;
        start = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        check("fl_busy", 32'(busy), 32'd0);
        check("fl_done", 32'(done), 32'd0);
        check("fl_idx", 32'(byte_idx), 32'd0);
        check("fl_res", result, 32'h0000_0078);
        check("fl_zero", 32'(zero), 32'd0);
        repeat (5) begin
            @(negedge clk);
            check("fl_idle", {30'd0, busy, done}, 32'd0);
        end
        run_op(2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "fl_nor");

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 32'h1234_5678;
        b     = 32'h0F0F_0000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ar_partial", result, 32'h0000_5678);
        #2 rst_n = 1'b0;
        #1;
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_done", 32'(done), 32'd0);
        check("ar_res", result, 32'd0);
        check("ar_zero", 32'(zero), 32'd0);
        check("ar_idx", 32'(byte_idx), 32'd0);
        repeat (2) @(negedge clk);
        check("ar_held", {30'd0, busy, done}, 32'd0);
        rst_n = 1'b1;
        run_op(2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, "ar_xor");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
